// File: rtl/fifo_modport.sv
// fifo_modport: synchronous single-clock FIFO with full/empty status.
//
// Stores up to DEPTH words of WIDTH bits and returns them in write order.
// Read data is registered: a read accepted on a rising edge presents the
// oldest entry on data_out after that edge. data_out holds its value
// whenever no read is accepted.
//
// Ports:
//   clk        single clock, all state updates on posedge
//   reset      synchronous active-high reset (pointers, count, data_out)
//   data_in    write data, captured when a write is accepted
//   write_enb  write request (dropped while full)
//   read       read request (ignored while empty)
//   data_out   registered read data
//   full       high when DEPTH entries are stored
//   empty      high when no entries are stored
module fifo_modport #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_enb,
  input  logic             read,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  // Pointer width is derived from DEPTH; DEPTH must be a power of two so the
  // pointers wrap naturally at DEPTH.
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             wr_acc, rd_acc;

  // Flags decode the registered count, so they only move after a clock edge
  // and can never be high together.
  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign data_out = data_out_q;

  always_comb begin
    wr_acc     = write_enb & ~full;
    rd_acc     = read & ~empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    // Reads see the pre-edge memory; an empty FIFO never bypasses the write
    // data straight to data_out.
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is not cleared by reset; a write coincident with reset is
  // suppressed so reset fully wins over the handshake.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_fifo_modport.sv
// Testbench for fifo_modport: table-driven vectors plus hand-written
// sequences, with a queue scoreboard holding the expected FIFO contents.
module tb_fifo_modport;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             write_enb;
  logic             read;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  fifo_modport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .write_enb (write_enb),
    .read      (read),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] exp_dout;

  typedef struct {
    logic             we;
    logic             rd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of handshake, update the scoreboard with pre-edge
  // acceptance, then compare outputs at the following negedge.
  task automatic step(input logic we, input logic rd, input logic [WIDTH-1:0] din);
    bit wacc, racc;
    write_enb = we;
    read      = rd;
    data_in   = din;
    wacc = we && (sb.size() < DEPTH);
    racc = rd && (sb.size() > 0);
    if (racc) exp_dout = sb.pop_front();
    if (wacc) sb.push_back(din);
    @(posedge clk);
    @(negedge clk);
    check("data_out", data_out, exp_dout);
    check("full", full, (sb.size() == DEPTH));
    check("empty", empty, (sb.size() == 0));
    write_enb = 1'b0;
    read      = 1'b0;
  endtask

  task automatic do_reset(input int cycles, input logic we, input logic [WIDTH-1:0] din);
    reset     = 1'b1;
    write_enb = we;
    read      = 1'b0;
    data_in   = din;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    write_enb = 1'b0;
    sb.delete();
    exp_dout = '0;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_data_out", data_out, 8'h00);
  endtask

  initial begin
    reset     = 1'b1;
    write_enb = 1'b0;
    read      = 1'b0;
    data_in   = '0;
    exp_dout  = '0;

    //             we    rd    din    dout   full  empty
    tbl[0] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'h44, 8'h11, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 8'h44, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 8'h44, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 8'h55, 8'h44, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1};

    // Reset held two cycles with a write pending: nothing may be stored.
    do_reset(2, 1'b1, 8'hAA);
    step(1'b0, 1'b1, 8'h00);
    check("rst_read_empty_dout", data_out, 8'h00);

    // Table: simultaneous read/write with 3 entries, and while empty.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].we, tbl[i].rd, tbl[i].din);
      check($sformatf("tbl%0d_dout", i), data_out, tbl[i].dout);
      check($sformatf("tbl%0d_full", i), full, tbl[i].full);
      check($sformatf("tbl%0d_empty", i), empty, tbl[i].empty);
    end

    // Fill 0x01..0x10, overflow write, drain in order, then underflow read.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i));
    check("fill_full", full, 1'b1);
    step(1'b1, 1'b0, 8'hFF);
    check("overflow_full", full, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d", i), data_out, 8'(i));
    end
    check("drain_empty", empty, 1'b1);
    step(1'b0, 1'b1, 8'h00);
    check("underflow_dout", data_out, 8'h10);

    // Full with both asserted: read accepted, write dropped.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i));
    step(1'b1, 1'b1, 8'h77);
    check("full_rw_dout", data_out, 8'hA0);
    check("full_rw_full", full, 1'b0);
    for (int i = 1; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    check("full_rw_last", data_out, 8'hAF);
    check("full_rw_empty", empty, 1'b1);

    // Wrap-around: one write per cycle with concurrent read, 40 cycles.
    step(1'b1, 1'b1, 8'h00);
    check("wrap_first_hold", data_out, 8'hAF);
    for (int i = 1; i < 40; i++) begin
      step(1'b1, 1'b1, 8'(i));
      check($sformatf("wrap%0d", i), data_out, 8'(i - 1));
    end
    step(1'b0, 1'b1, 8'h00);
    check("wrap_last", data_out, 8'h27);
    check("wrap_empty", empty, 1'b1);

    // Mid-operation reset with 10 entries stored.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
    do_reset(1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h9C);
    step(1'b0, 1'b1, 8'h00);
    check("post_reset_dout", data_out, 8'h9C);
    check("post_reset_empty", empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
